// File: rtl/cache_pkg.sv
// Shared types and geometry for the cache memory-side arbiter.
// A block of 2**BLOCK_SIZE words moves as BEATS beats of WR_M_DATA_SIZE words.
package cache_pkg;

    localparam int ADDR_SIZE      = 32;
    localparam int DATA_SIZE      = 32;
    localparam int BLOCK_SIZE     = 6;
    localparam int WR_M_DATA_SIZE = 4;
    localparam int BEATS          = (2 ** BLOCK_SIZE) / WR_M_DATA_SIZE;
    localparam int BEAT_CNT_W     = $clog2(BEATS);
    localparam int OFFSET_BITS    = BLOCK_SIZE + $clog2(DATA_SIZE / 8);

    // Clears the byte offset within a block; alignment is a pure mask.
    localparam logic [ADDR_SIZE-1:0] ADDR_MASK =
        {{(ADDR_SIZE - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

    typedef logic [ADDR_SIZE-1:0]                      addr_t;
    typedef logic [WR_M_DATA_SIZE-1:0][DATA_SIZE-1:0]  beat_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } arb_state_t;

    function automatic logic is_last_beat(input logic [BEAT_CNT_W-1:0] cnt);
        return cnt == BEAT_CNT_W'(BEATS - 1);
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Client-side and memory-side signals of the cache memory arbiter.
// Every channel is valid/ready: a beat or request transfers on the clock edge
// where both valid and ready are high; valid may not depend on ready.
interface cache_mem_arbiter_if #(
    parameter int NUM_CLIENTS = 2
);
    import cache_pkg::*;

    logic  [NUM_CLIENTS-1:0]        c_req_valid;
    logic  [NUM_CLIENTS-1:0]        c_req_rw;
    addr_t [NUM_CLIENTS-1:0]        c_req_addr;
    logic  [NUM_CLIENTS-1:0]        c_req_ready;
    logic  [NUM_CLIENTS-1:0]        c_wr_valid;
    beat_t [NUM_CLIENTS-1:0]        c_wr_data;
    logic  [NUM_CLIENTS-1:0]        c_wr_ready;
    logic  [NUM_CLIENTS-1:0]        c_rd_valid;
    beat_t                          c_rd_data;
    logic                           c_rd_last;

    logic                           m_req_valid;
    logic                           m_req_ready;
    addr_t                          m_req_addr;
    logic                           m_req_rw;
    logic                           m_wr_valid;
    beat_t                          m_wr_data;
    logic                           m_wr_last;
    logic                           m_wr_ready;
    logic                           m_rd_valid;
    beat_t                          m_rd_data;
    logic                           m_rd_ready;

    modport master (
        input  c_req_valid, c_req_rw, c_req_addr, c_wr_valid, c_wr_data,
        output c_req_ready, c_wr_ready, c_rd_valid, c_rd_data, c_rd_last,
        output m_req_valid, m_req_addr, m_req_rw, m_wr_valid, m_wr_data,
        output m_wr_last, m_rd_ready,
        input  m_req_ready, m_wr_ready, m_rd_valid, m_rd_data
    );

    modport slave (
        output c_req_valid, c_req_rw, c_req_addr, c_wr_valid, c_wr_data,
        input  c_req_ready, c_wr_ready, c_rd_valid, c_rd_data, c_rd_last,
        input  m_req_valid, m_req_addr, m_req_rw, m_wr_valid, m_wr_data,
        input  m_wr_last, m_rd_ready,
        output m_req_ready, m_wr_ready, m_rd_valid, m_rd_data
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin selector: first set request after i_last_grant,
// searching upward with wrap-around.
module rr_priority_pick #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last_grant,
    output logic [IW-1:0] o_gnt_idx,
    output logic          o_gnt_any
);

    int w_cand;

    always_comb begin
        o_gnt_idx = '0;
        o_gnt_any = 1'b0;
        w_cand    = 0;
        for (int i = 1; i <= N; i++) begin
            w_cand = (int'(i_last_grant) + i) % N;
            if (!o_gnt_any && i_req[IW'(w_cand)]) begin
                o_gnt_idx = IW'(w_cand);
                o_gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin owner of the shared memory refill/writeback channel; a grant
// covers one address phase plus a full block of write or read beats.
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter  int NUM_CLIENTS = 2,
    localparam int GW          = $clog2(NUM_CLIENTS)
) (
    input  logic                clk,
    input  logic                rst,
    cache_mem_arbiter_if.master bus,
    output logic [GW-1:0]       grant_id,
    output arb_state_t          o_state
);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [BEAT_CNT_W-1:0] r_beat_cnt;
    logic [BEAT_CNT_W-1:0] w_beat_cnt_nxt;
    logic [GW-1:0]         r_last_grant;
    logic [GW-1:0]         r_grant_id;
    addr_t                 r_addr;
    logic                  r_rw;
    logic [GW-1:0]         w_pick_idx;
    logic                  w_pick_any;
    logic                  w_last;

    rr_priority_pick #(
        .N (NUM_CLIENTS)
    ) u_pick (
        .i_req        (bus.c_req_valid),
        .i_last_grant (r_last_grant),
        .o_gnt_idx    (w_pick_idx),
        .o_gnt_any    (w_pick_any)
    );

    assign w_last   = is_last_beat(r_beat_cnt);
    assign grant_id = r_grant_id;
    assign o_state  = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_beat_cnt   <= '0;
            r_last_grant <= GW'(NUM_CLIENTS - 1);
            r_grant_id   <= '0;
            r_addr       <= '0;
            r_rw         <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            // The request is captured here so later client changes are ignored.
            if (r_state == IDLE && w_pick_any) begin
                r_grant_id   <= w_pick_idx;
                r_last_grant <= w_pick_idx;
                r_addr       <= bus.c_req_addr[w_pick_idx] & ADDR_MASK;
                r_rw         <= bus.c_req_rw[w_pick_idx];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_beat_cnt_nxt  = r_beat_cnt;
        bus.c_req_ready = '0;
        bus.c_wr_ready  = '0;
        bus.c_rd_valid  = '0;
        bus.c_rd_data   = '0;
        bus.c_rd_last   = 1'b0;
        bus.m_req_valid = 1'b0;
        bus.m_req_addr  = r_addr;
        bus.m_req_rw    = r_rw;
        bus.m_wr_valid  = 1'b0;
        bus.m_wr_data   = '0;
        bus.m_wr_last   = 1'b0;
        bus.m_rd_ready  = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = ADDR;
                end
            end
            ADDR: begin
                bus.m_req_valid = 1'b1;
                if (bus.m_req_ready) begin
                    bus.c_req_ready[r_grant_id] = 1'b1;
                    w_beat_cnt_nxt              = '0;
                    w_state_nxt                 = r_rw ? WDATA : RDATA;
                end
            end
            WDATA: begin
                bus.m_wr_valid             = bus.c_wr_valid[r_grant_id];
                bus.m_wr_data              = bus.c_wr_data[r_grant_id];
                bus.m_wr_last              = w_last;
                bus.c_wr_ready[r_grant_id] = bus.m_wr_ready;
                if (bus.c_wr_valid[r_grant_id] && bus.m_wr_ready) begin
                    w_beat_cnt_nxt = w_last ? '0 : r_beat_cnt + 1'b1;
                    if (w_last) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            RDATA: begin
                // Clients cannot stall reads, so ready is unconditional.
                bus.m_rd_ready             = 1'b1;
                bus.c_rd_valid[r_grant_id] = bus.m_rd_valid;
                bus.c_rd_data              = bus.m_rd_data;
                bus.c_rd_last              = w_last;
                if (bus.m_rd_valid) begin
                    w_beat_cnt_nxt = w_last ? '0 : r_beat_cnt + 1'b1;
                    if (w_last) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Round-robin arbiter that shares one memory refill/writeback channel between NUM_CLIENTS cache cores (e.g. I-cache and D-cache instances of cache_top).
- A grant is held for one whole block transaction: address phase, then BEATS write beats or BEATS read beats.
- Sits between the caches' memory-side interfaces and the AXI4 master bridge.

Parameters:
- NUM_CLIENTS, 2, number of requesting caches (2..8)
- ADDR_SIZE, 32, address width
- DATA_SIZE, 32, word width
- BLOCK_SIZE, 6, log2 of words per block
- WR_M_DATA_SIZE, 4, words per memory beat
- BEATS, (2**BLOCK_SIZE)/WR_M_DATA_SIZE = 16, beats per block transaction

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- c_req_valid  in  NUM_CLIENTS  per-client block request
- c_req_rw  in  NUM_CLIENTS  1 = writeback, 0 = load
- c_req_addr  in  NUM_CLIENTS x ADDR_SIZE  request address
- c_req_ready  out  NUM_CLIENTS  one-cycle accept pulse to the granted client
- c_wr_valid  in  NUM_CLIENTS  client write beat valid
- c_wr_data  in  NUM_CLIENTS x WR_M_DATA_SIZE x DATA_SIZE  client write beat
- c_wr_ready  out  NUM_CLIENTS  write beat accepted
- c_rd_valid  out  NUM_CLIENTS  read beat valid
- c_rd_data  out  WR_M_DATA_SIZE x DATA_SIZE  read beat, shared by all clients
- c_rd_last  out  1  final read beat
- m_req_valid  out  1  memory address valid
- m_req_ready  in  1  memory address accepted
- m_req_addr  out  ADDR_SIZE  block-aligned address
- m_req_rw  out  1  transaction direction
- m_wr_valid  out  1  write beat valid
- m_wr_data  out  WR_M_DATA_SIZE x DATA_SIZE  write beat
- m_wr_last  out  1  final write beat
- m_wr_ready  in  1  memory accepts write beat
- m_rd_valid  in  1  read beat valid
- m_rd_data  in  WR_M_DATA_SIZE x DATA_SIZE  read beat
- m_rd_ready  out  1  arbiter accepts read beat
- grant_id  out  $clog2(NUM_CLIENTS)  current owner, for debug

Behaviour:
- Reset (async, rst=1): state IDLE, beat_cnt 0, rr pointer last_grant = NUM_CLIENTS-1 so client 0 has highest priority. grant_id and all registered outputs are 0. All valid, ready and pulse outputs are 0.
- IDLE:
  - If any c_req_valid is set, select the first requester searching from last_grant+1 with wrap-around.
  - On the next edge, register grant_id, latch addr with the low BLOCK_SIZE+log2(DATA_SIZE/8) bits cleared, latch rw, update last_grant, go to ADDR.
  - No request: stay in IDLE. One cycle of grant latency.
- ADDR: m_req_valid=1 with the latched addr/rw, held stable until m_req_ready.
  - On m_req_valid&&m_req_ready: c_req_ready[grant_id] pulses for exactly that cycle (combinational from the handshake). Next state is WDATA if rw=1, else RDATA; beat_cnt is cleared.
- WDATA: pure combinational pass-through with zero latency.
  - m_wr_valid = c_wr_valid[g]; m_wr_data = c_wr_data[g]; c_wr_ready[g] = m_wr_ready; m_wr_last = (beat_cnt == BEATS-1).
  - beat_cnt increments on each handshake. The handshake on the last beat returns the arbiter to IDLE.
- RDATA: pure combinational pass-through with zero latency.
  - c_rd_valid[g] = m_rd_valid; m_rd_ready = 1; c_rd_data = m_rd_data; c_rd_last = (beat_cnt == BEATS-1).
  - A client may not stall read beats. The last beat returns the arbiter to IDLE.
- Non-granted clients see c_req_ready, c_wr_ready and c_rd_valid at 0 at all times.
- The latched request is immune to the client dropping or changing c_req_* after grant. Dropping before c_req_ready is a protocol violation; the transaction still completes.
- Simultaneous requests from all clients: strict rotation, one full block each. No client waits more than NUM_CLIENTS-1 transactions.
- A new request arriving in the same cycle as the last beat is seen in IDLE on the following cycle. This gives one idle bubble between transactions, which is required.
- Reset asserted mid-burst: the transaction is abandoned immediately and all outputs drop. The memory side must also be reset.
- Width rules: beat_cnt is $clog2(BEATS) bits wide with no wrap past BEATS-1. Address alignment uses a mask, never arithmetic.

Decomposition:
- Package cache_pkg holds:
  - localparams BEATS and OFFSET_BITS;
  - the typedef beat_t (logic [WR_M_DATA_SIZE-1:0][DATA_SIZE-1:0]);
  - the enum arb_state_t {IDLE, ADDR, WDATA, RDATA}.
- Sub-module rr_priority_pick: combinational round-robin selector taking req, last_grant and returning gnt_idx and gnt_any. Reused by future arbiters.

Test Plan:
- Single load: client 0 requests rw=0, addr 32'h00001234 → m_req_addr = 32'h00001200 after 1-cycle grant. After m_req_ready, 16 beats with values 32'h1000+i reach client 0 only. c_rd_last is set on beat 15. Arbiter returns to IDLE.
- Single writeback: client 1 requests rw=1, addr 32'h10001234 → c_req_ready[1] pulses one cycle. 16 beats are forwarded and m_wr_last is set only on beat 15. Random m_wr_ready stalls are back-pressured to c_wr_ready[1] exactly.
- Contention: both clients request in the same cycle after reset → client 0 is served first, then client 1. With both re-requesting, the grant order alternates 0,1,0,1 for 4 transactions.
- Stable request: client 0 changes c_req_addr to 32'hFFFF0000 while m_req_ready is held low for 5 cycles → m_req_addr stays 32'h00001200 and m_req_valid stays high throughout.
- Reset mid-read: assert rst after beat 7 → m_req_valid, m_rd_ready and c_rd_valid go to 0 asynchronously. After release, a client 1 request is granted from IDLE with beat_cnt = 0.
- Back-to-back: client 0 re-requests in the cycle of its last beat → exactly one IDLE cycle passes, then the new address phase starts.
